// File: rtl/switch_bank_reader_pkg.sv
`default_nettype none
// ============================================================================
// Module      : switch_bank_reader_pkg
// Description : Shared defaults and the debounce counter-width helper for the
//               switch bank reader and its per-bit debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
package switch_bank_reader_pkg;

  localparam int DEFAULT_WIDTH           = 16;
  localparam int DEFAULT_DEBOUNCE_CYCLES = 100000;

  // Counter width for a debounce window of 'cycles'. The counter only has to
  // reach cycles-1, so clog2(cycles) bits is enough. The result is floored at
  // one bit so that very short windows still get a legal vector.
  function automatic int cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage : switch_bank_reader_pkg
`default_nettype wire

// File: rtl/switch_debounce.sv
`default_nettype none
// ============================================================================
// Module      : switch_debounce
// Description : One switch bit. A two-flop synchronizer feeds a stability
//               counter, and the debounced level toggles only after the
//               synchronized input has differed from it for DEBOUNCE_CYCLES
//               consecutive cycles.
// Ports       : clk      - clock, rising edge
//               rst      - asynchronous reset, active low
//               sw_async - raw switch level
//               value    - debounced level
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debounce
  import switch_bank_reader_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic sw_async,
  output logic value
);

  localparam int                 CNT_W   = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q,   cnt_d;
  logic             value_q, value_d;

  always_comb begin
    sync1_d = sw_async;
    sync2_d = sync1_q;
    cnt_d   = '0;
    value_d = value_q;
    if (sync2_q != value_q) begin
      // The terminal count is reached on the cycle in which the input has
      // differed for the full window, so the toggle lands on that same edge.
      if (cnt_q == CNT_MAX) begin
        value_d = ~value_q;
        cnt_d   = '0;
      end else begin
        cnt_d   = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      value_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      cnt_q   <= cnt_d;
      value_q <= value_d;
    end
  end

  assign value = value_q;

endmodule : switch_debounce
`default_nettype wire

// File: rtl/switch_bank_reader.sv
`default_nettype none
// ============================================================================
// Module      : switch_bank_reader
// Description : Debounced switch bank. It detects changes and offers
//               snapshots to a consumer through a valid/ready handshake. If a
//               new snapshot replaces one that was never accepted, a sticky
//               overrun flag is set.
// Ports       : clk         - clock, rising edge
//               rst         - asynchronous reset, active low
//               sw          - raw switch levels
//               value       - debounced switch state
//               changed     - one-cycle pulse when any value bit flips
//               data        - snapshot offered to the consumer
//               data_valid  - data holds an unconsumed snapshot
//               data_ready  - consumer accepts data while data_valid is high
//               overrun     - sticky: snapshot overwritten before acceptance
//               overrun_clr - synchronous clear of overrun
// Revision    : 1.0 - initial release
// ============================================================================
module switch_bank_reader
  import switch_bank_reader_pkg::*;
#(
  parameter int WIDTH           = DEFAULT_WIDTH,
  parameter int DEBOUNCE_CYCLES = DEFAULT_DEBOUNCE_CYCLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] sw,
  output logic [WIDTH-1:0] value,
  output logic             changed,
  output logic [WIDTH-1:0] data,
  output logic             data_valid,
  input  logic             data_ready,
  output logic             overrun,
  input  logic             overrun_clr
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    switch_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .rst      (rst),
      .sw_async (sw[i]),
      .value    (value[i])
    );
  end

  logic [WIDTH-1:0] value_prev_q, value_prev_d;
  logic [WIDTH-1:0] data_q,       data_d;
  logic             data_valid_q, data_valid_d;
  logic             overrun_q,    overrun_d;
  logic             accept;

  // The pulse is decoded against last cycle's value. It is therefore high in
  // exactly the cycle in which value is new, and a multi-bit flip produces a
  // single pulse.
  assign changed = |(value ^ value_prev_q);
  assign accept  = data_valid_q & data_ready;

  always_comb begin
    value_prev_d = value;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    overrun_d    = overrun_q;

    if (overrun_clr) begin
      overrun_d = 1'b0;
    end

    if (changed) begin
      data_d       = value;
      data_valid_d = 1'b1;
      // Losing an unaccepted snapshot sets overrun. This assignment comes
      // after the clear, so a set in the same cycle as a clear wins.
      if (data_valid_q && !data_ready) begin
        overrun_d = 1'b1;
      end
    end else if (accept) begin
      data_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value_prev_q <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      value_prev_q <= value_prev_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign data       = data_q;
  assign data_valid = data_valid_q;
  assign overrun    = overrun_q;

endmodule : switch_bank_reader
`default_nettype wire

// File: tb/tb_switch_bank_reader.sv
`default_nettype none
// ============================================================================
// Module      : tb_switch_bank_reader
// Description : Directed self-checking bench for switch_bank_reader
//               (WIDTH=16, DEBOUNCE_CYCLES=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_bank_reader;

  logic        clk;
  logic        rst;
  logic [15:0] sw;
  logic [15:0] value;
  logic        changed;
  logic [15:0] data;
  logic        data_valid;
  logic        data_ready;
  logic        overrun;
  logic        overrun_clr;

  int pass_cnt  = 0;
  int total_cnt = 0;

  switch_bank_reader #(
    .WIDTH           (16),
    .DEBOUNCE_CYCLES (4)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .sw          (sw),
    .value       (value),
    .changed     (changed),
    .data        (data),
    .data_valid  (data_valid),
    .data_ready  (data_ready),
    .overrun     (overrun),
    .overrun_clr (overrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One rising edge, then settle 1 ns before sampling or driving.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst         = 1'b0;
    sw          = 16'h0000;
    data_ready  = 1'b0;
    overrun_clr = 1'b0;
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    logic bad;
    rst         = 1'b0;
    sw          = 16'h0000;
    data_ready  = 1'b0;
    overrun_clr = 1'b0;
    #3;
    total_cnt++;
    if ({value, changed, data, data_valid, overrun} !== 35'd0)
      $display("FAIL reset_outputs: got value=%h changed=%b data=%h valid=%b overrun=%b, expected all 0",
               value, changed, data, data_valid, overrun);
    else pass_cnt++;
    tick();
    tick();
    rst = 1'b1;
    bad = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (value !== 16'h0000 || changed !== 1'b0 || data_valid !== 1'b0 || overrun !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL idle_hold: got activity during 100 idle cycles (value=%h), expected none", value);
    else pass_cnt++;
  endtask

  task automatic test_debounce();
    logic early;
    logic unstable;
    int   pulses;
    early  = 1'b0;
    pulses = 0;
    sw = 16'h00A5;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (value !== 16'h0000) early = 1'b1;
      if (changed === 1'b1) pulses++;
    end
    total_cnt++;
    if (early) $display("FAIL a5_early: got value=%h before edge 6, expected 0000", value);
    else pass_cnt++;
    tick();
    if (changed === 1'b1) pulses++;
    total_cnt++;
    if (value !== 16'h00A5 || changed !== 1'b1)
      $display("FAIL a5_edge6: got value=%h changed=%b, expected 00a5 1", value, changed);
    else pass_cnt++;
    tick();
    if (changed === 1'b1) pulses++;
    total_cnt++;
    if (data !== 16'h00A5 || data_valid !== 1'b1)
      $display("FAIL a5_snapshot: got data=%h valid=%b, expected 00a5 1", data, data_valid);
    else pass_cnt++;
    unstable = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (changed === 1'b1) pulses++;
      if (data !== 16'h00A5 || data_valid !== 1'b1) unstable = 1'b1;
    end
    total_cnt++;
    if (pulses != 1) $display("FAIL a5_pulse_count: got %0d changed pulses, expected 1", pulses);
    else pass_cnt++;
    total_cnt++;
    if (unstable) $display("FAIL a5_hold: got data=%h valid=%b while waiting, expected 00a5 1", data, data_valid);
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    total_cnt++;
    if (data_valid !== 1'b0 || data !== 16'h00A5)
      $display("FAIL a5_accept: got valid=%b data=%h, expected 0 00a5", data_valid, data);
    else pass_cnt++;
  endtask

  task automatic test_glitch();
    logic bad;
    do_reset();
    sw = 16'h0001;
    for (int i = 0; i < 3; i++) tick();
    sw  = 16'h0000;
    bad = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (value !== 16'h0000 || changed !== 1'b0) bad = 1'b1;
    end
    total_cnt++;
    if (bad) $display("FAIL glitch_reject: got value=%h after 3-cycle pulse, expected 0000, no changed", value);
    else pass_cnt++;
    sw = 16'h0001;
    for (int i = 0; i < 5; i++) tick();
    total_cnt++;
    if (value !== 16'h0000) $display("FAIL glitch_restart_early: got value=%h at edge 5, expected 0000", value);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (value !== 16'h0001) $display("FAIL glitch_restart: got value=%h at edge 6, expected 0001", value);
    else pass_cnt++;
  endtask

  task automatic test_accept_coincide();
    do_reset();
    sw = 16'h0001;
    for (int i = 0; i < 7; i++) tick();
    sw = 16'h0003;
    for (int i = 0; i < 6; i++) tick();
    total_cnt++;
    if (changed !== 1'b1 || data_valid !== 1'b1)
      $display("FAIL coincide_pre: got changed=%b valid=%b, expected 1 1", changed, data_valid);
    else pass_cnt++;
    data_ready = 1'b1;
    tick();
    data_ready = 1'b0;
    total_cnt++;
    if (data !== 16'h0003 || data_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL coincide_accept: got data=%h valid=%b overrun=%b, expected 0003 1 0",
               data, data_valid, overrun);
    else pass_cnt++;
  endtask

  task automatic test_overrun();
    do_reset();
    sw = 16'h0001;
    for (int i = 0; i < 7; i++) tick();
    total_cnt++;
    if (data !== 16'h0001 || data_valid !== 1'b1 || overrun !== 1'b0)
      $display("FAIL ovr_first: got data=%h valid=%b overrun=%b, expected 0001 1 0", data, data_valid, overrun);
    else pass_cnt++;
    sw = 16'h0003;
    for (int i = 0; i < 7; i++) tick();
    total_cnt++;
    if (data !== 16'h0003 || data_valid !== 1'b1 || overrun !== 1'b1)
      $display("FAIL ovr_set: got data=%h valid=%b overrun=%b, expected 0003 1 1", data, data_valid, overrun);
    else pass_cnt++;
    overrun_clr = 1'b1;
    tick();
    overrun_clr = 1'b0;
    total_cnt++;
    if (overrun !== 1'b0 || data !== 16'h0003 || data_valid !== 1'b1)
      $display("FAIL ovr_clear: got overrun=%b data=%h valid=%b, expected 0 0003 1", overrun, data, data_valid);
    else pass_cnt++;
    // Clear is held across the overwrite; the set in that cycle must win.
    sw          = 16'h0007;
    overrun_clr = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    overrun_clr = 1'b0;
    total_cnt++;
    if (overrun !== 1'b1 || data !== 16'h0007)
      $display("FAIL ovr_set_wins: got overrun=%b data=%h, expected 1 0007", overrun, data);
    else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    logic early;
    sw = 16'hFFFF;
    for (int i = 0; i < 4; i++) tick();
    #2;
    rst = 1'b0;
    #1;
    total_cnt++;
    if ({value, changed, data, data_valid, overrun} !== 35'd0)
      $display("FAIL async_reset: got value=%h changed=%b data=%h valid=%b overrun=%b, expected all 0",
               value, changed, data, data_valid, overrun);
    else pass_cnt++;
    tick();
    tick();
    rst   = 1'b1;
    early = 1'b0;
    for (int e = 1; e <= 5; e++) begin
      tick();
      if (value !== 16'h0000) early = 1'b1;
    end
    total_cnt++;
    if (early) $display("FAIL post_reset_early: got value=%h before edge 6, expected 0000", value);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (value !== 16'hFFFF || changed !== 1'b1)
      $display("FAIL post_reset_value: got value=%h changed=%b, expected ffff 1", value, changed);
    else pass_cnt++;
    tick();
    total_cnt++;
    if (data !== 16'hFFFF || data_valid !== 1'b1)
      $display("FAIL post_reset_snapshot: got data=%h valid=%b, expected ffff 1", data, data_valid);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_glitch();
    test_accept_coincide();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_switch_bank_reader
`default_nettype wire
